// File: rtl/sap2_pkg.sv
// Shared SAP-II definitions for the serial receive port.
//   rx_state_e : receiver FSM state encoding
//   DATA_BITS  : payload bits per serial frame
//   IDLE_LEVEL : level of an idle serial line
package sap2_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_rx_port_if.sv
// CPU-side handshake bundle of the serial receive port.
//   Ers        : drive FIFO head onto rx_BUS
//   ack        : one-cycle pop of the FIFO head
//   clr_err    : clear sticky error flags
//   rx_BUS     : FIFO head (or 8'h00) toward WBUS
//   ready      : FIFO not empty
//   frame_err  : sticky stop-bit error
//   overrun    : sticky dropped-byte error
//   parity_err : sticky parity error, only with SERIAL_RX_PARITY_EN defined
// master = CPU side, slave = receive port.
interface serial_rx_port_if;

    logic       Ers;
    logic       ack;
    logic       clr_err;
    logic [7:0] rx_BUS;
    logic       ready;
    logic       frame_err;
    logic       overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
        output Ers, ack, clr_err,
`ifdef SERIAL_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_BUS, ready, frame_err, overrun
    );

    modport slave (
        input  Ers, ack, clr_err,
`ifdef SERIAL_RX_PARITY_EN
        output parity_err,
`endif
        output rx_BUS, ready, frame_err, overrun
    );

endinterface

// File: rtl/rx_fifo.sv
// Byte FIFO for received serial data.
//   clk, rst_n : clock, synchronous active-low reset
//   push, data : write request and byte (dropped when full unless popping)
//   pop        : read request (ignored when empty)
//   head       : oldest entry, valid when !empty
//   empty/full : occupancy status
module rx_fifo
    import sap2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] data,
    output logic [DATA_BITS-1:0] head,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem[rd_ptr_q];

    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data;
    end

endmodule

// File: rtl/serial_rx_port.sv
// SAP-II serial receive port: deserialises idle-high async frames
// (start, 8 data LSB first, [even parity], stop) into a byte FIFO read
// through the WBUS ready/ack handshake.
//   CLK       : system clock
//   nCLR      : synchronous active-low reset
//   serial_in : asynchronous serial line
//   bus       : CPU handshake (slave side of serial_rx_port_if)
// Optional feature macro: SERIAL_RX_PARITY_EN adds the parity bit,
// PARITY state and parity_err flag.
module serial_rx_port
    import sap2_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               nCLR,
    input  logic               serial_in,
    serial_rx_port_if.slave    bus
);

    localparam int unsigned          TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]        LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]        HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]           LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [1:0]           sync_q;
    logic [TW-1:0]        timer_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 frame_err_q;
    logic                 overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    logic                 parity_bad_q;
    logic                 parity_err_q;
`endif

    logic                 rxs;
    logic                 tick;
    logic                 push_req;
    logic                 overrun_evt;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign rxs  = sync_q[1];
    assign tick = (timer_q == LAST_TICK);

    // Push is combinational so the byte lands on the stop-sample edge itself.
`ifdef SERIAL_RX_PARITY_EN
    assign push_req = (state_q == RX_STOP) && tick && rxs && !parity_bad_q;
`else
    assign push_req = (state_q == RX_STOP) && tick && rxs;
`endif
    assign overrun_evt = push_req && fifo_full && !bus.ack;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nCLR),
        .push  (push_req),
        .pop   (bus.ack),
        .data  (shreg_q),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            sync_q       <= {2{IDLE_LEVEL}};
            state_q      <= RX_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], serial_in};

            // Clear first so a same-edge error below overrides it.
            if (bus.clr_err) begin
                frame_err_q  <= 1'b0;
                overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            if (overrun_evt) overrun_q <= 1'b1;

            unique case (state_q)
                RX_IDLE: begin
                    timer_q <= '0;
                    if (rxs != IDLE_LEVEL) state_q <= RX_START;
                end
                RX_START: begin
                    if (timer_q == HALF_TICK) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        timer_q   <= '0;
                        shreg_q   <= {rxs, shreg_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_q <= RX_PARITY;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                RX_PARITY: begin
                    if (tick) begin
                        timer_q      <= '0;
                        parity_bad_q <= ^{shreg_q, rxs};
                        if (^{shreg_q, rxs}) parity_err_q <= 1'b1;
                        state_q      <= RX_STOP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (tick) begin
                        timer_q <= '0;
                        if (!rxs) frame_err_q <= 1'b1;
                        state_q <= RX_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.ready     = !fifo_empty;
    assign bus.rx_BUS    = (bus.Ers && !fifo_empty) ? fifo_head : 8'h00;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx_port.sv
// Self-checking bench for serial_rx_port: directed scenarios plus random
// frames compared against a queue-based model of received bytes and flags.
// Honours SERIAL_RX_PARITY_EN.
module tb_serial_rx_port;

    localparam int unsigned C = 16;
    localparam int unsigned D = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge (counted from the first edge seeing the start bit) that pushes the byte.
    localparam int PUSH_EDGE = 2 + C / 2 + (NB - 1) * C;

    logic CLK = 1'b0;
    logic nCLR = 1'b0;
    logic serial_in = 1'b1;

    serial_rx_port_if bus ();

    serial_rx_port #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .CLK       (CLK),
        .nCLR      (nCLR),
        .serial_in (serial_in),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       exp_frame = 1'b0;
    logic       exp_over  = 1'b0;
    logic       exp_par   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.ready), 32'(exp_q.size() != 0));
        check_eq({tag, "_frame_err"}, 32'(bus.frame_err), 32'(exp_frame));
        check_eq({tag, "_overrun"}, 32'(bus.overrun), 32'(exp_over));
`ifdef SERIAL_RX_PARITY_EN
        check_eq({tag, "_parity_err"}, 32'(bus.parity_err), 32'(exp_par));
`endif
        check_eq({tag, "_bus_idle"}, 32'(bus.rx_BUS), 32'h0);
        bus.Ers = 1'b1;
        #1;
        if (exp_q.size() != 0) check_eq({tag, "_head"}, 32'(bus.rx_BUS), 32'(exp_q[0]));
        else                   check_eq({tag, "_head"}, 32'(bus.rx_BUS), 32'h0);
        bus.Ers = 1'b0;
        #1;
    endtask

    task automatic pop(input string tag);
        bus.Ers = 1'b1;
        bus.ack = 1'b1;
        #1;
        if (exp_q.size() != 0) check_eq(tag, 32'(bus.rx_BUS), 32'(exp_q[0]));
        else                   check_eq(tag, 32'(bus.rx_BUS), 32'h0);
        @(posedge CLK);
        #1;
        bus.Ers = 1'b0;
        bus.ack = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_errors();
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        exp_frame = 1'b0;
        exp_over  = 1'b0;
        exp_par   = 1'b0;
    endtask

    // Outcome of one complete frame under the receive rules.
    task automatic model_frame(input logic [7:0] data, input logic stop, input logic pflip,
                               input logic ack_at_push);
        logic bad;
`ifdef SERIAL_RX_PARITY_EN
        bad = pflip;
`else
        bad = 1'b0 & pflip;
`endif
        if (bad) exp_par = 1'b1;
        if (!stop) begin
            exp_frame = 1'b1;
        end else if (!bad) begin
            if (ack_at_push && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_q.size() < D) exp_q.push_back(data);
            else                  exp_over = 1'b1;
        end
    endtask

    // Drives one frame; reset_edge >= 0 pulses nCLR at that edge and aborts.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic pflip,
                              input logic ack_at_push, input int reset_edge,
                              output int rise_edge);
        logic [NB-1:0] bits;
        logic          was_ready;
        bits       = '0;
        bits[0]    = 1'b0;
        bits[8:1]  = data;
`ifdef SERIAL_RX_PARITY_EN
        bits[9]    = (^data) ^ pflip;
`endif
        bits[NB-1] = stop;
        rise_edge  = -1;
        was_ready  = bus.ready;
        for (int e = 0; e < NB * int'(C); e++) begin
            serial_in = bits[e / int'(C)];
            if (ack_at_push && e == PUSH_EDGE) bus.ack = 1'b1;
            if (e == reset_edge) nCLR = 1'b0;
            @(posedge CLK);
            #1;
            bus.ack = 1'b0;
            if (e == reset_edge) begin
                nCLR = 1'b1;
                break;
            end
            if (rise_edge < 0 && !was_ready && bus.ready) rise_edge = e;
        end
        serial_in = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] data, input logic stop, input logic pflip,
                           input logic ack_at_push);
        int re;
        send_frame(data, stop, pflip, ack_at_push, -1, re);
        model_frame(data, stop, pflip, ack_at_push);
        // A low stop bit must clear the line before the next start bit.
        if (!stop) tick(C);
    endtask

    initial begin
        int re;
        bus.Ers     = 1'b0;
        bus.ack     = 1'b0;
        bus.clr_err = 1'b0;

        // Reset state
        tick(3);
        check_outputs("reset");
        nCLR = 1'b1;
        tick(2);

        // Single byte with latency
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, re);
        model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_eq("push_latency", 32'(re), 32'(PUSH_EDGE));
        check_outputs("single");
        pop("single_pop");
        check_outputs("single_after_pop");

        // Glitch rejection
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(2 * C);
        check_outputs("glitch");

        // Framing error
        rx_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        check_outputs("frame");
        clear_errors();
        check_outputs("frame_clr");

        // Overrun
        for (int i = 1; i <= 5; i++) rx_byte(8'(i), 1'b1, 1'b0, 1'b0);
        check_outputs("overrun");
        for (int i = 0; i < 4; i++) pop("overrun_pop");
        check_outputs("overrun_drained");
        clear_errors();

        // Simultaneous push/pop on a full FIFO
        for (int i = 1; i <= 4; i++) rx_byte(8'(i), 1'b1, 1'b0, 1'b0);
        rx_byte(8'h05, 1'b1, 1'b0, 1'b1);
        check_outputs("simul");
        for (int i = 0; i < 4; i++) pop("simul_pop");
        check_outputs("simul_drained");

        // Reset mid-frame (DATA bit 4) with state to lose
        rx_byte(8'h77, 1'b1, 1'b0, 1'b0);
        rx_byte(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 2 + 5 * int'(C), re);
        exp_q.delete();
        exp_frame = 1'b0;
        exp_over  = 1'b0;
        exp_par   = 1'b0;
        tick(2);
        check_outputs("reset_mid");
        rx_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        check_outputs("after_reset");
        pop("after_reset_pop");

`ifdef SERIAL_RX_PARITY_EN
        // Bad parity
        rx_byte(8'h5A, 1'b1, 1'b1, 1'b0);
        check_outputs("parity");
        clear_errors();
        check_outputs("parity_clr");
`endif

        // Random frames
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       stop;
            logic       pflip;
            logic       ackp;
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 5) != 0);
            pflip = ($urandom_range(0, 4) == 0);
            ackp  = ($urandom_range(0, 3) == 0);
            rx_byte(d, stop, pflip, ackp);
            check_outputs("rand");
            if ($urandom_range(0, 1) == 1) pop("rand_pop");
            if ($urandom_range(0, 3) == 0) clear_errors();
            tick($urandom_range(0, 20));
        end
        while (exp_q.size() != 0) pop("rand_drain");
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
